// File: rtl/matmul_pkg.sv
// Shared types and sizing helpers for the matrix-multiply engine.
package matmul_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StLoadA,
    StLoadB,
    StCompute,
    StDrain
  } state_e;

  // Row/column index width; kept at least one bit so N=1 still builds.
  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Width able to hold an element count from 0 to n*n.
  function automatic int unsigned cnt_width(input int unsigned n);
    return $clog2(n * n + 1);
  endfunction

endpackage

// File: rtl/matmul_mac.sv
// Multiply-accumulate: DW x DW product extended to ACCW, registered accumulator.
module matmul_mac
  import matmul_pkg::*;
#(
  parameter int unsigned DW     = 8,
  parameter int unsigned ACCW   = 2 * DW + 3,
  parameter int unsigned SIGNED = 0
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            enable,
  input  logic            clear,
  input  logic [DW-1:0]   a,
  input  logic [DW-1:0]   b,
  output logic [ACCW-1:0] sum
);

  logic [2*DW-1:0] prod;
  logic [ACCW-1:0] prod_ext;
  logic [ACCW-1:0] acc_q;
  logic            sign;

  // Product of the extended operands; low 2*DW bits equal the signed or unsigned product.
  always_comb begin
    if (SIGNED != 0) begin
      prod = {{DW{a[DW-1]}}, a} * {{DW{b[DW-1]}}, b};
    end else begin
      prod = {{DW{1'b0}}, a} * {{DW{1'b0}}, b};
    end
    sign     = (SIGNED != 0) && prod[2*DW-1];
    prod_ext = {{(ACCW - 2 * DW){sign}}, prod};
    sum      = acc_q + prod_ext;
  end

  // Accumulate when enabled; clear restarts the next dot product from zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q <= '0;
    end else if (enable) begin
      acc_q <= clear ? '0 : sum;
    end
  end

endmodule

// File: rtl/matmul_engine.sv
// Streamed square-matrix multiplier: load A and B, compute C with one MAC, drain C.
module matmul_engine
  import matmul_pkg::*;
#(
  parameter int unsigned N      = 4,
  parameter int unsigned DW     = 8,
  parameter int unsigned ACCW   = 2 * DW + $clog2(N) + 1,
  parameter int unsigned SIGNED = 0
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic [$clog2(N+1)-1:0] dim,
  input  logic [DW-1:0]          in_data,
  input  logic                   in_valid,
  output logic                   in_ready,
  output logic [ACCW-1:0]        out_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic                   busy,
  output logic                   done,
  output logic                   err
);

  localparam int unsigned DimW = $clog2(N + 1);
  localparam int unsigned IdxW = idx_width(N);
  localparam logic [DimW-1:0] DimMax = DimW'(N);

  state_e            state_q, state_d;
  logic [DimW-1:0]   dim_q, dim_d;
  logic [IdxW-1:0]   r_q, r_d, c_q, c_d, k_q, k_d;
  logic              in_ready_q, in_ready_d;
  logic              out_valid_q, out_valid_d;
  logic [ACCW-1:0]   out_data_q, out_data_d;
  logic              busy_q, busy_d, done_q, done_d, err_q, err_d;

  logic [DW-1:0]     a_mem [N][N];
  logic [DW-1:0]     b_mem [N][N];
  logic [ACCW-1:0]   c_mem [N][N];

  logic              a_we, b_we, c_we, mac_en, mac_clr;
  logic [ACCW-1:0]   mac_sum;
  logic [IdxW-1:0]   last_idx, nxt_r, nxt_c;
  logic              row_last, col_last, k_last, in_hs, out_hs, dim_ok;

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign err       = err_q;

  // r/c walk row-major during load, act as i/j in compute and as the drain index.
  always_comb begin
    last_idx = IdxW'(dim_q - 1'b1);
    row_last = (r_q == last_idx);
    col_last = (c_q == last_idx);
    k_last   = (k_q == last_idx);
    nxt_c    = col_last ? '0 : c_q + 1'b1;
    nxt_r    = col_last ? r_q + 1'b1 : r_q;
    in_hs    = in_valid && in_ready_q;
    out_hs   = out_valid_q && out_ready;
    dim_ok   = (dim != '0) && (dim <= DimMax);
  end

  matmul_mac #(
    .DW    (DW),
    .ACCW  (ACCW),
    .SIGNED(SIGNED)
  ) u_mac (
    .clk   (clk),
    .rst_n (rst_n),
    .enable(mac_en),
    .clear (mac_clr),
    .a     (a_mem[r_q][k_q]),
    .b     (b_mem[k_q][c_q]),
    .sum   (mac_sum)
  );

  // Next-state and registered-output logic.
  always_comb begin
    state_d     = state_q;
    dim_d       = dim_q;
    r_d         = r_q;
    c_d         = c_q;
    k_d         = k_q;
    in_ready_d  = in_ready_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    err_d       = 1'b0;
    a_we        = 1'b0;
    b_we        = 1'b0;
    c_we        = 1'b0;
    mac_en      = 1'b0;
    mac_clr     = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          if (dim_ok) begin
            dim_d      = dim;
            r_d        = '0;
            c_d        = '0;
            k_d        = '0;
            in_ready_d = 1'b1;
            busy_d     = 1'b1;
            mac_en     = 1'b1;
            mac_clr    = 1'b1;
            state_d    = StLoadA;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      StLoadA, StLoadB: begin
        if (in_hs) begin
          a_we = (state_q == StLoadA);
          b_we = (state_q == StLoadB);
          c_d  = nxt_c;
          r_d  = nxt_r;
          if (row_last && col_last) begin
            r_d = '0;
            if (state_q == StLoadA) begin
              state_d = StLoadB;
            end else begin
              in_ready_d = 1'b0;
              k_d        = '0;
              state_d    = StCompute;
            end
          end
        end
      end
      StCompute: begin
        mac_en = 1'b1;
        k_d    = k_q + 1'b1;
        if (k_last) begin
          c_we    = 1'b1;
          mac_clr = 1'b1;
          k_d     = '0;
          c_d     = nxt_c;
          r_d     = nxt_r;
          if (row_last && col_last) begin
            r_d         = '0;
            out_valid_d = 1'b1;
            // For dim=1 the only element is being written this very cycle.
            out_data_d  = (dim_q == DimW'(1)) ? mac_sum : c_mem[0][0];
            state_d     = StDrain;
          end
        end
      end
      StDrain: begin
        if (out_hs) begin
          if (row_last && col_last) begin
            out_valid_d = 1'b0;
            done_d      = 1'b1;
            busy_d      = 1'b0;
            state_d     = StIdle;
          end else begin
            c_d        = nxt_c;
            r_d        = nxt_r;
            out_data_d = c_mem[nxt_r][nxt_c];
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Control and output registers; reset aborts any transfer in progress.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      dim_q       <= '0;
      r_q         <= '0;
      c_q         <= '0;
      k_q         <= '0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      dim_q       <= dim_d;
      r_q         <= r_d;
      c_q         <= c_d;
      k_q         <= k_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      err_q       <= err_d;
    end
  end

  // Matrix storage; contents are don't-care after reset.
  always_ff @(posedge clk) begin
    if (a_we) a_mem[r_q][c_q] <= in_data;
    if (b_we) b_mem[r_q][c_q] <= in_data;
    if (c_we) c_mem[r_q][c_q] <= mac_sum;
  end

endmodule

// File: tb/tb_matmul_engine.sv
// Directed bench for matmul_engine: vector table plus hand-written corner sequences.
module tb_matmul_engine;

  localparam int unsigned N    = 4;
  localparam int unsigned DW   = 8;
  localparam int unsigned ACCW = 2 * DW + $clog2(N) + 1;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            start = 1'b0;
  logic [2:0]      dim = '0;
  logic [DW-1:0]   in_data = '0;
  logic            in_valid = 1'b0;
  logic            in_ready;
  logic [ACCW-1:0] out_data;
  logic            out_valid;
  logic            out_ready = 1'b0;
  logic            busy, done, err;

  logic            s_start = 1'b0;
  logic [2:0]      s_dim = '0;
  logic [DW-1:0]   s_in_data = '0;
  logic            s_in_valid = 1'b0;
  logic            s_in_ready;
  logic [ACCW-1:0] s_out_data;
  logic            s_out_valid;
  logic            s_out_ready = 1'b0;
  logic            s_busy, s_done, s_err;

  matmul_engine #(.N(N), .DW(DW), .SIGNED(0)) u_dut (
    .clk(clk), .rst_n(rst_n), .start(start), .dim(dim),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .busy(busy), .done(done), .err(err)
  );

  matmul_engine #(.N(N), .DW(DW), .SIGNED(1)) u_dut_s (
    .clk(clk), .rst_n(rst_n), .start(s_start), .dim(s_dim),
    .in_data(s_in_data), .in_valid(s_in_valid), .in_ready(s_in_ready),
    .out_data(s_out_data), .out_valid(s_out_valid), .out_ready(s_out_ready),
    .busy(s_busy), .done(s_done), .err(s_err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int failures = 0;

  typedef struct packed {
    logic [2:0]        dim;
    logic [15:0][7:0]  a;
    logic [15:0][7:0]  b;
    logic [15:0][31:0] c;
    logic              toggle;
    logic              drain_start;
  } vec_t;

  vec_t vecs [4];
  bit [3:0] pat = 4'b1001;

  int unsigned a2 [4] = '{1, 2, 3, 4};
  int unsigned b2 [4] = '{5, 6, 7, 8};
  int unsigned c2 [4] = '{19, 22, 43, 50};
  int unsigned a3 [9] = '{1, 2, 3, 4, 5, 6, 7, 8, 9};
  int unsigned b3 [9] = '{9, 8, 7, 6, 5, 4, 3, 2, 1};
  int unsigned c3 [9] = '{30, 24, 18, 84, 69, 54, 138, 114, 90};

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_vec(input vec_t v, output int u);
    int nn = int'(v.dim) * int'(v.dim);
    int idx = 0;
    int guard = 0;
    logic hs;
    start = 1'b1;
    dim   = v.dim;
    tick();
    start = 1'b0;
    chk("busy_after_start", busy, 1);
    chk("in_ready_after_start", in_ready, 1);
    in_valid = 1'b1;
    while (idx < 2 * nn && guard < 200) begin
      in_data = (idx < nn) ? v.a[idx] : v.b[idx - nn];
      hs = in_ready;
      tick();
      if (hs) idx++;
      guard++;
    end
    in_valid = 1'b0;
    u = cyc - 1;
    chk("load_count", idx, 2 * nn);
    chk("load_no_bubble", guard, 2 * nn);
    chk("in_ready_after_load", in_ready, 0);
  endtask

  task automatic run_vec(input vec_t v);
    int u;
    int n = int'(v.dim);
    int nn = n * n;
    int k = 0;
    int p = 0;
    int guard = 0;
    int inj = 0;
    logic hs;
    load_vec(v, u);
    while (!out_valid && guard < 200) begin
      tick();
      guard++;
    end
    chk("first_out_valid_latency", cyc - u, n * n * n + 1);
    while (k < nn && guard < 400) begin
      out_ready = v.toggle ? pat[p % 4] : 1'b1;
      p++;
      if (v.drain_start && k == 1 && inj == 0) begin
        start = 1'b1;
        dim   = 3'd0;
        inj   = 1;
      end
      chk("out_valid_in_drain", out_valid, 1);
      chk("out_data", out_data, v.c[k]);
      hs = out_valid && out_ready;
      tick();
      start = 1'b0;
      if (inj == 1) begin
        chk("no_err_start_in_drain", err, 0);
        chk("busy_start_in_drain", busy, 1);
        inj = 2;
      end
      if (hs) k++;
      guard++;
    end
    out_ready = 1'b0;
    chk("drain_count", k, nn);
    chk("done_pulse", done, 1);
    chk("busy_after_done", busy, 0);
    chk("out_valid_after_done", out_valid, 0);
    tick();
    chk("done_one_cycle", done, 0);
  endtask

  task automatic run_signed(input logic [7:0] a, input logic [7:0] b, input logic [31:0] exp);
    int guard = 0;
    s_start = 1'b1;
    s_dim   = 3'd1;
    tick();
    s_start    = 1'b0;
    s_in_valid = 1'b1;
    s_in_data  = a;
    tick();
    s_in_data = b;
    tick();
    s_in_valid = 1'b0;
    while (!s_out_valid && guard < 20) begin
      tick();
      guard++;
    end
    chk("signed_out_valid", s_out_valid, 1);
    chk("signed_out_data", s_out_data, exp);
    s_out_ready = 1'b1;
    tick();
    s_out_ready = 1'b0;
    chk("signed_done", s_done, 1);
    tick();
  endtask

  task automatic bad_start(input logic [2:0] d);
    start = 1'b1;
    dim   = d;
    tick();
    start = 1'b0;
    chk("err_pulse", err, 1);
    chk("err_busy_low", busy, 0);
    chk("err_in_ready_low", in_ready, 0);
    tick();
    chk("err_one_cycle", err, 0);
    chk("err_still_idle", busy, 0);
  endtask

  initial begin
    int u;
    for (int i = 0; i < 4; i++) vecs[i] = '0;
    vecs[0].dim = 3'd2;
    for (int i = 0; i < 4; i++) begin
      vecs[0].a[i] = 8'(a2[i]);
      vecs[0].b[i] = 8'(b2[i]);
      vecs[0].c[i] = c2[i];
    end
    vecs[1].dim = 3'd4;
    for (int i = 0; i < 16; i++) begin
      vecs[1].a[i] = 8'd255;
      vecs[1].b[i] = 8'd255;
      vecs[1].c[i] = 32'd260100;
    end
    vecs[2].dim  = 3'd1;
    vecs[2].a[0] = 8'd200;
    vecs[2].b[0] = 8'd3;
    vecs[2].c[0] = 32'd600;
    vecs[3].dim         = 3'd3;
    vecs[3].toggle      = 1'b1;
    vecs[3].drain_start = 1'b1;
    for (int i = 0; i < 9; i++) begin
      vecs[3].a[i] = 8'(a3[i]);
      vecs[3].b[i] = 8'(b3[i]);
      vecs[3].c[i] = c3[i];
    end

    repeat (2) tick();
    chk("rst_in_ready", in_ready, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);
    rst_n = 1'b1;
    tick();

    for (int i = 0; i < 4; i++) run_vec(vecs[i]);

    bad_start(3'd0);
    bad_start(3'd5);

    // Abort a dim=4 job partway through COMPUTE, then rerun a small one.
    load_vec(vecs[1], u);
    repeat (19) tick();
    chk("pre_reset_busy", busy, 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst_in_ready", in_ready, 0);
    chk("async_rst_out_valid", out_valid, 0);
    chk("async_rst_out_data", out_data, 0);
    chk("async_rst_busy", busy, 0);
    chk("async_rst_done", done, 0);
    chk("async_rst_err", err, 0);
    tick();
    rst_n = 1'b1;
    tick();
    run_vec(vecs[0]);

    run_signed(8'h80, 8'h80, 32'd16384);
    run_signed(8'hFD, 8'h05, 32'h7FFF1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/matmul_engine.md
# matmul_engine

Parametrised square-matrix multiplier: receives A and B as a byte-wide valid/ready stream, computes C = A×B with a single sequential MAC, and streams C out element by element. Runtime dimension `dim` ranges 1..N; data width, maximum dimension, accumulator width and signedness are compile-time parameters. It sits between the UART receive/transmit path and the control unit, replacing the fixed-size memories and multiplier with one self-sequencing block.

## Interface
- `N`, 4: maximum matrix dimension.
- `DW`, 8: element width of A and B.
- `ACCW`, 2*DW+$clog2(N)+1: accumulator and result width.
- `SIGNED`, 0: 1 means two's-complement elements and products; 0 means unsigned.

Ports (one clock; reset is asynchronous and active-low):
- `clk` in 1: system clock.
- `rst_n` in 1: asynchronous active-low reset.
- `start` in 1: single-cycle request, sampled only in IDLE.
- `dim` in $clog2(N+1): matrix dimension, latched on an accepted `start`.
- `in_data` in DW: A elements then B elements, row-major.
- `in_valid` in 1: `in_data` is valid.
- `in_ready` out 1: the engine accepts input.
- `out_data` out ACCW: C elements, row-major.
- `out_valid` out 1: `out_data` is valid.
- `out_ready` in 1: the downstream sink accepts output.
- `busy` out 1: high in every state except IDLE.
- `done` out 1: one-cycle pulse after the final C handshake.
- `err` out 1: one-cycle pulse when `start` arrives with `dim`==0 or `dim`>N.

## Operation
- States: IDLE, LOAD_A, LOAD_B, COMPUTE, DRAIN.
- IDLE, `start`, valid `dim`: latch `dim`, clear indices, go to LOAD_A.
- IDLE, `start`, invalid `dim`: pulse `err`, stay in IDLE.
- LOAD_A: each handshake (`in_valid`&&`in_ready`) writes A[i][k]. After dim² elements, go to LOAD_B.
- LOAD_B: loads B the same way. After dim² elements, go to COMPUTE.
- COMPUTE: i, j, k loop with k innermost. Each cycle computes acc += A[i][k]*B[k][j].
  - When k==dim-1, the block writes C[i][j] = acc + product and clears acc.
  - After i=j=k=dim-1, go to DRAIN.
- DRAIN: presents C row-major. The index advances on each handshake (`out_valid`&&`out_ready`). After the final handshake: pulse `done`, go to IDLE.
- Arithmetic:
  - Products are sign- or zero-extended to ACCW according to `SIGNED`.
  - Sums wrap modulo 2^ACCW with no saturation. The default ACCW cannot overflow for dim≤N.
- `start` outside IDLE is ignored; it causes no error.
- While loading, bytes with `in_ready` low are not consumed.
- Asserting `rst_n` low at any time forces IDLE and all outputs to their reset values.
  - Partially loaded matrices are discarded.
  - A, B and C array contents need not be cleared.

## Timing
- All outputs are registered. Reset values: `in_ready`=0, `out_valid`=0, `out_data`=0, `busy`=0, `done`=0, `err`=0.
- `start` accepted at cycle t: `busy`=1 and `in_ready`=1 from t+1.
- `in_ready` stays high throughout LOAD_A and LOAD_B. There is no bubble between the last A and first B element.
- The last B handshake at cycle u: `in_ready`=0 from u+1; COMPUTE occupies u+1 .. u+dim³.
- First `out_valid` is at u+dim³+1.
- DRAIN back-pressure:
  - `out_data` stays stable while `out_valid` && !`out_ready`.
  - With `out_ready` held high, one element is delivered per cycle.
- Final output handshake at cycle v: `done`=1 at v+1, `busy`=0 at v+1, and `start` is accepted again from v+1.
- `err` asserts the cycle after the offending `start`.

## Structure
- Shared package `matmul_pkg` holds:
  - the state encoding constants;
  - helper constants: index width $clog2(N) and count width $clog2(N*N+1).
- One sub-module, `matmul_mac`: a registered DW×DW multiply with SIGNED-controlled extension into an ACCW accumulator.
  - Inputs: clear and enable.
  - Output: sum, exposing acc + product.
- The three N×N arrays, the FSM and all index counters stay in `matmul_engine`.

## Test plan
- `dim`=2, unsigned; A=[1,2,3,4], B=[5,6,7,8] -> C=[19,22,43,50]; `out_valid` first at u+9; `done` after the 4th handshake.
- `dim`=4, unsigned, all elements 255 -> all 16 C elements = 260100, with no wrap.
- `SIGNED`=1, `dim`=1; A=-128, B=-128 -> C=16384. A=-3, B=5 -> C=-15, sign-extended to ACCW.
- `start` with `dim`=0, then with `dim`=N+1 -> `err` pulses each time; `busy` stays 0; `in_ready` stays 0.
- `dim`=3 with `out_ready` toggling 1,0,0,1 -> 9 elements in row-major order; `out_data` stable during stalls; `start` during DRAIN ignored.
- Reset mid-COMPUTE (`dim`=4, after 20 COMPUTE cycles) -> all outputs at reset values asynchronously. A following `dim`=2 run produces correct C.
